// File: rtl/cog_vidq_if.sv
// rtl/cog_vidq_if.sv - WAITVID queue signal bundle between the cog, the queue and the video shifter
interface cog_vidq_if;
    logic        flush;
    logic        push;
    logic [31:0] push_pixel;
    logic [31:0] push_color;
    logic        stall;
    logic        ack;
    logic [31:0] pixel;
    logic [31:0] color;
    logic [4:0]  level;
    logic        underrun;
    logic [7:0]  urcnt;

    modport master (
        output flush,
        output push,
        output push_pixel,
        output push_color,
        output ack,
        input  stall,
        input  pixel,
        input  color,
        input  level,
        input  underrun,
        input  urcnt
    );

    modport slave (
        input  flush,
        input  push,
        input  push_pixel,
        input  push_color,
        input  ack,
        output stall,
        output pixel,
        output color,
        output level,
        output underrun,
        output urcnt
    );
endinterface

// File: rtl/cog_vidq.sv
// rtl/cog_vidq.sv - WAITVID entry queue between cog and video shifter; underrun counter under COG_VIDQ_UNDERRUN_EN
module cog_vidq #(
    parameter int DEPTH = 4
) (
    input  logic       clk_cog,
    input  logic       res,
    cog_vidq_if.slave  vq
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL_LVL = 5'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } occ_t;

    occ_t          state_q;
    occ_t          state_d;
    logic [4:0]    level_q;
    logic [4:0]    level_d;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          ack_d;
    logic [31:0]   hold_pixel;
    logic [31:0]   hold_color;
    logic [31:0]   mem_pixel [DEPTH];
    logic [31:0]   mem_color [DEPTH];

    logic          cap_ev;
    logic          stall_c;
    logic          do_push;
    logic          do_pop;

    // The shifter acknowledges with a level; only its rising edge consumes an entry.
    assign cap_ev  = vq.ack & ~ack_d;

    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign stall_c = ~vq.flush & vq.push & (state_q == FULL) & ~cap_ev;
    assign do_push = vq.push & ~stall_c & ~vq.flush;
    assign do_pop  = cap_ev & (state_q != EMPTY) & ~vq.flush;

    always_comb begin
        level_d = level_q;
        state_d = state_q;
        if (vq.flush) begin
            level_d = 5'd0;
        end else if (do_push && !do_pop) begin
            level_d = level_q + 5'd1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 5'd1;
        end

        if (level_d == 5'd0) begin
            state_d = EMPTY;
        end else if (level_d == FULL_LVL) begin
            state_d = FULL;
        end else begin
            state_d = PARTIAL;
        end
    end

    always_ff @(posedge clk_cog) begin
        if (res) begin
            state_q    <= EMPTY;
            level_q    <= 5'd0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            ack_d      <= 1'b0;
            hold_pixel <= 32'd0;
            hold_color <= 32'd0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            ack_d   <= vq.ack;
            if (vq.flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr     <= rd_ptr + 1'b1;
                    hold_pixel <= mem_pixel[rd_ptr];
                    hold_color <= mem_color[rd_ptr];
                end
            end
        end
    end

    always_ff @(posedge clk_cog) begin
        if (do_push && !res) begin
            mem_pixel[wr_ptr] <= vq.push_pixel;
            mem_color[wr_ptr] <= vq.push_color;
        end
    end

    // On starvation the shifter keeps seeing the last entry it consumed.
    assign vq.pixel = (state_q == EMPTY) ? hold_pixel : mem_pixel[rd_ptr];
    assign vq.color = (state_q == EMPTY) ? hold_color : mem_color[rd_ptr];
    assign vq.level = level_q;
    assign vq.stall = stall_c;

`ifdef COG_VIDQ_UNDERRUN_EN
    logic       underrun_q;
    logic [7:0] urcnt_q;

    always_ff @(posedge clk_cog) begin
        if (res) begin
            underrun_q <= 1'b0;
            urcnt_q    <= 8'd0;
        end else if (cap_ev && (state_q == EMPTY) && !vq.flush) begin
            underrun_q <= 1'b1;
            if (urcnt_q != 8'hFF) begin
                urcnt_q <= urcnt_q + 8'd1;
            end
        end
    end

    assign vq.underrun = underrun_q;
    assign vq.urcnt    = urcnt_q;
`else
    assign vq.underrun = 1'b0;
    assign vq.urcnt    = 8'd0;
`endif

endmodule

// File: tb/tb_cog_vidq.sv
// tb/tb_cog_vidq.sv - directed self-checking bench for cog_vidq at DEPTH=4
module tb_cog_vidq;

`ifdef COG_VIDQ_UNDERRUN_EN
    localparam bit UR_EN = 1'b1;
`else
    localparam bit UR_EN = 1'b0;
`endif

    logic clk_cog;
    logic res;
    int   checks;
    int   errors;

    cog_vidq_if vq ();

    cog_vidq #(.DEPTH(4)) dut (
        .clk_cog (clk_cog),
        .res     (res),
        .vq      (vq.slave)
    );

    initial clk_cog = 1'b0;
    always #5 clk_cog = ~clk_cog;

    task automatic tick();
        @(posedge clk_cog);
        #1;
    endtask

    task automatic push_one(input logic [31:0] p);
        vq.push       = 1'b1;
        vq.push_pixel = p;
        vq.push_color = ~p;
        tick();
        vq.push       = 1'b0;
    endtask

    task automatic ack_edge();
        vq.ack = 1'b1;
        tick();
        vq.ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        res = 1'b1;
        vq.push = 1'b1;
        vq.push_pixel = 32'hDEAD_BEEF;
        vq.push_color = 32'h1234_5678;
        tick();
        res = 1'b0;
        vq.push = 1'b0;
        #1;
        checks++;
        if (vq.level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", vq.level); end
        checks++;
        if (vq.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", vq.stall); end
        checks++;
        if (vq.pixel !== 32'd0 || vq.color !== 32'd0) begin
            errors++; $display("FAIL reset_out: got %h/%h expected 0/0", vq.pixel, vq.color);
        end
        checks++;
        if (vq.underrun !== 1'b0 || vq.urcnt !== 8'd0) begin
            errors++; $display("FAIL reset_ur: got %b/%0d expected 0/0", vq.underrun, vq.urcnt);
        end
    endtask

    task automatic test_fifo_order();
        push_one(32'hA0A0_0001);
        checks++;
        if (vq.level !== 5'd1 || vq.pixel !== 32'hA0A0_0001) begin
            errors++; $display("FAIL latency: got lvl %0d px %h expected 1 a0a00001", vq.level, vq.pixel);
        end
        push_one(32'hB0B0_0002);
        push_one(32'hC0C0_0003);
        checks++;
        if (vq.level !== 5'd3 || vq.pixel !== 32'hA0A0_0001) begin
            errors++; $display("FAIL fill3: got lvl %0d px %h expected 3 a0a00001", vq.level, vq.pixel);
        end
        ack_edge();
        checks++;
        if (vq.level !== 5'd2 || vq.pixel !== 32'hB0B0_0002) begin
            errors++; $display("FAIL pop1: got lvl %0d px %h expected 2 b0b00002", vq.level, vq.pixel);
        end
        ack_edge();
        checks++;
        if (vq.level !== 5'd1 || vq.pixel !== 32'hC0C0_0003) begin
            errors++; $display("FAIL pop2: got lvl %0d px %h expected 1 c0c00003", vq.level, vq.pixel);
        end
        ack_edge();
        checks++;
        if (vq.level !== 5'd0 || vq.pixel !== 32'hC0C0_0003 || vq.color !== 32'h3F3F_FFFC) begin
            errors++; $display("FAIL repeat_last: got lvl %0d px %h col %h expected 0 c0c00003 3f3ffffc",
                               vq.level, vq.pixel, vq.color);
        end
    endtask

    task automatic test_stall();
        logic [31:0] d [5];
        for (int i = 0; i < 5; i++) d[i] = 32'h5000_0000 + 32'(i);
        for (int i = 0; i < 4; i++) begin
            vq.push = 1'b1;
            vq.push_pixel = d[i];
            vq.push_color = ~d[i];
            #1;
            checks++;
            if (vq.stall !== 1'b0) begin errors++; $display("FAIL stall_early%0d: got 1 expected 0", i); end
            tick();
        end
        vq.push_pixel = d[4];
        vq.push_color = ~d[4];
        #1;
        checks++;
        if (vq.stall !== 1'b1 || vq.level !== 5'd4) begin
            errors++; $display("FAIL stall_full: got stall %b lvl %0d expected 1 4", vq.stall, vq.level);
        end
        tick();
        checks++;
        if (vq.stall !== 1'b1 || vq.level !== 5'd4) begin
            errors++; $display("FAIL stall_hold: got stall %b lvl %0d expected 1 4", vq.stall, vq.level);
        end
        vq.ack = 1'b1;
        #1;
        checks++;
        if (vq.stall !== 1'b0) begin errors++; $display("FAIL stall_release: got 1 expected 0"); end
        tick();
        vq.push = 1'b0;
        checks++;
        if (vq.level !== 5'd4 || vq.pixel !== d[1]) begin
            errors++; $display("FAIL full_pushpop: got lvl %0d px %h expected 4 %h", vq.level, vq.pixel, d[1]);
        end
        for (int k = 2; k <= 4; k++) begin
            vq.ack = 1'b0;
            tick();
            vq.ack = 1'b1;
            tick();
            checks++;
            if (vq.level !== 5'(5 - k) || vq.pixel !== d[k]) begin
                errors++; $display("FAIL drain%0d: got lvl %0d px %h expected %0d %h", k, vq.level, vq.pixel, 5 - k, d[k]);
            end
        end
        vq.ack = 1'b0;
        tick();
        ack_edge();
        checks++;
        if (vq.level !== 5'd0 || vq.pixel !== d[4]) begin
            errors++; $display("FAIL drain_last: got lvl %0d px %h expected 0 %h", vq.level, vq.pixel, d[4]);
        end
    endtask

    task automatic test_ack_hold();
        push_one(32'h1111_0001);
        push_one(32'h2222_0002);
        vq.ack = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (vq.level !== 5'd1 || vq.pixel !== 32'h2222_0002) begin
            errors++; $display("FAIL ack_level: got lvl %0d px %h expected 1 22220002", vq.level, vq.pixel);
        end
        vq.ack = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        push_one(32'h3333_0003);
        push_one(32'h4444_0004);
        checks++;
        if (vq.level !== 5'd3) begin errors++; $display("FAIL flush_pre: got %0d expected 3", vq.level); end
        vq.flush = 1'b1;
        vq.push = 1'b1;
        vq.push_pixel = 32'h9999_9999;
        vq.push_color = 32'h6666_6666;
        #1;
        checks++;
        if (vq.stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got 1 expected 0"); end
        tick();
        vq.flush = 1'b0;
        vq.push = 1'b0;
        tick();
        checks++;
        if (vq.level !== 5'd0 || vq.pixel !== 32'h1111_0001 || vq.color !== 32'hEEEE_FFFE) begin
            errors++; $display("FAIL flush_hold: got lvl %0d px %h col %h expected 0 11110001 eeeefffe",
                               vq.level, vq.pixel, vq.color);
        end
        push_one(32'h7777_0007);
        checks++;
        if (vq.level !== 5'd1 || vq.pixel !== 32'h7777_0007) begin
            errors++; $display("FAIL flush_after: got lvl %0d px %h expected 1 77770007", vq.level, vq.pixel);
        end
    endtask

    task automatic test_push_on_empty_edge();
        ack_edge();
        vq.ack = 1'b1;
        push_one(32'h8888_0008);
        vq.ack = 1'b0;
        checks++;
        if (vq.level !== 5'd1 || vq.pixel !== 32'h8888_0008) begin
            errors++; $display("FAIL empty_edge_push: got lvl %0d px %h expected 1 88880008", vq.level, vq.pixel);
        end
        checks++;
        if (vq.urcnt !== (UR_EN ? 8'd1 : 8'd0)) begin
            errors++; $display("FAIL empty_edge_ur: got %0d expected %0d", vq.urcnt, UR_EN ? 1 : 0);
        end
        tick();
    endtask

    task automatic test_underrun();
        ack_edge();
        for (int i = 0; i < 10; i++) ack_edge();
        checks++;
        if (vq.urcnt !== (UR_EN ? 8'd11 : 8'd0)) begin
            errors++; $display("FAIL urcnt_11: got %0d expected %0d", vq.urcnt, UR_EN ? 11 : 0);
        end
        for (int i = 0; i < 290; i++) ack_edge();
        checks++;
        if (vq.urcnt !== (UR_EN ? 8'd255 : 8'd0) || vq.underrun !== UR_EN) begin
            errors++; $display("FAIL urcnt_sat: got %0d/%b expected %0d/%b", vq.urcnt, vq.underrun,
                               UR_EN ? 255 : 0, UR_EN);
        end
        checks++;
        if (vq.level !== 5'd0 || vq.pixel !== 32'h8888_0008) begin
            errors++; $display("FAIL starve_px: got lvl %0d px %h expected 0 88880008", vq.level, vq.pixel);
        end
        vq.flush = 1'b1;
        tick();
        vq.flush = 1'b0;
        tick();
        checks++;
        if (vq.urcnt !== (UR_EN ? 8'd255 : 8'd0) || vq.underrun !== UR_EN) begin
            errors++; $display("FAIL ur_flush: got %0d/%b expected %0d/%b", vq.urcnt, vq.underrun,
                               UR_EN ? 255 : 0, UR_EN);
        end
    endtask

    task automatic test_back_to_back_and_reset();
        push_one(32'hE000_0001);
        push_one(32'hE000_0002);
        vq.ack = 1'b1;
        push_one(32'hE000_0003);
        vq.ack = 1'b0;
        checks++;
        if (vq.level !== 5'd2 || vq.pixel !== 32'hE000_0002) begin
            errors++; $display("FAIL pushpop_partial: got lvl %0d px %h expected 2 e0000002", vq.level, vq.pixel);
        end
        res = 1'b1;
        tick();
        res = 1'b0;
        #1;
        checks++;
        if (vq.level !== 5'd0 || vq.pixel !== 32'd0 || vq.stall !== 1'b0) begin
            errors++; $display("FAIL midreset: got lvl %0d px %h stall %b expected 0 0 0", vq.level, vq.pixel, vq.stall);
        end
        checks++;
        if (vq.urcnt !== 8'd0 || vq.underrun !== 1'b0) begin
            errors++; $display("FAIL midreset_ur: got %0d/%b expected 0/0", vq.urcnt, vq.underrun);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        res = 1'b1;
        vq.flush = 1'b0;
        vq.push = 1'b0;
        vq.push_pixel = 32'd0;
        vq.push_color = 32'd0;
        vq.ack = 1'b0;
        tick();
        tick();
        test_reset();
        test_fifo_order();
        test_stall();
        test_ack_hold();
        test_flush();
        test_push_on_empty_edge();
        test_underrun();
        test_back_to_back_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cog_vidq.md
Cog_vidq -- requirements
Module: cog_vidq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the queue depth in entries; legal values are 2, 4, 8 and 16.
REQ-002 SHALL have port clk_cog, in, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port res, in, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port flush, in, 1 bit: synchronous queue clear, asserted when the video enable drops.
REQ-005 SHALL have port push, in, 1 bit: the cog offers one WAITVID entry this cycle.
REQ-006 SHALL have port push_pixel, in, 32 bits: pixel long of the offered entry.
REQ-007 SHALL have port push_color, in, 32 bits: color long of the offered entry.
REQ-008 SHALL have port stall, out, 1 bit: push not accepted this cycle; the cog holds the instruction.
REQ-009 SHALL have port ack, in, 1 bit: level acknowledge from the video shifter, already synchronized to clk_cog.
REQ-010 SHALL have port pixel, out, 32 bits: head-entry pixel long presented to the shifter.
REQ-011 SHALL have port color, out, 32 bits: head-entry color long presented to the shifter.
REQ-012 SHALL have port level, out, 5 bits: current occupancy, 0..DEPTH.
REQ-013 SHALL have port underrun, out, 1 bit: sticky flag; 0 when REQ-033 is compiled out.
REQ-014 SHALL have port urcnt, out, 8 bits: saturating underrun count; 0 when REQ-033 is compiled out.

Function
REQ-015 SHALL store entries in a circular buffer of DEPTH {pixel,color} pairs with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-016 SHALL register ack into ack_d each cycle; the capture event cap_ev = ack & ~ack_d.
REQ-017 SHALL perform a pop on cap_ev when level>0: advance the read pointer and decrement level.
REQ-018 SHALL drive pixel/color combinationally from the head entry when level>0.
REQ-019 SHALL, when level==0, drive pixel/color from a hold register containing the last popped entry (repeat-last on starvation).
REQ-020 SHALL perform a push on push & ~stall: write at the write pointer, advance it, and increment level.
REQ-021 SHALL define stall = push & (level==DEPTH) & ~(cap_ev).
REQ-022 SHALL, at full with a simultaneous cap_ev, accept the push; level stays DEPTH.
REQ-023 SHALL, on simultaneous push and pop at 0<level<DEPTH, leave level unchanged and move both pointers.
REQ-024 SHALL, on push at level==0 with a coincident cap_ev, write the entry into the queue, ignore the pop for the queue, and count an underrun.
REQ-025 SHALL load the hold register with the popped head entry on every pop.
REQ-026 SHALL give push-to-visible latency of 1 cycle: an entry pushed into an empty queue appears on pixel/color the next cycle.
REQ-027 SHALL on flush zero both pointers and level, clear ack_d to the current ack, and keep the hold register; flush overrides push and pop in the same cycle, and stall=0 while flush=1.
REQ-028 SHALL keep occupancy states EMPTY (level 0), PARTIAL and FULL (level DEPTH), with transitions only by REQ-017, REQ-020 and REQ-027.

Reset
REQ-029 SHALL, while res=1 at a clock edge, zero the pointers, level, ack_d, the hold register, underrun and urcnt.
REQ-030 SHALL give res priority over flush, push and ack.
REQ-031 SHALL hold stall=0 and pixel=color=0 in the cycle after reset.
REQ-032 SHALL discard an entry being pushed in the reset cycle.

Configuration
REQ-033 SHALL, with macro COG_VIDQ_UNDERRUN_EN defined, set underrun and increment urcnt (saturating at 255) on every cap_ev with level==0; both clear only on res; flush does not clear them.
REQ-034 SHALL, without COG_VIDQ_UNDERRUN_EN, tie underrun=0 and urcnt=0 and implement no counter logic; all other behaviour is identical.

Verification
REQ-035 SHALL cover: push A,B,C with DEPTH=4, then three ack rising edges -> pixel shows A, B, C in turn, then C repeats, level 3->0.
REQ-036 SHALL cover: push 5 entries back-to-back with no ack -> stall=1 on the 5th only, level=4, the 5th retried and accepted on the next ack edge.
REQ-037 SHALL cover: ack held high for 3 cycles -> exactly one pop.
REQ-038 SHALL cover: with the macro defined, 300 ack edges while empty -> underrun=1, urcnt=255; without the macro, both stay 0.
REQ-039 SHALL cover: flush at level=3 with push in the same cycle -> level=0, the entry is dropped, pixel equals the last popped value.
REQ-040 SHALL cover: res asserted mid-operation with level=2 -> next cycle level=0, pixel=0, stall=0, urcnt=0.
